// File: rtl/sfu_accum_if.sv
// Handshake and data bundle between the OFIFO/core side (master) and the sfu_accum stage (slave).
interface sfu_accum_if #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8
);
    logic [3:0]             kij;
    logic                   ofifo_valid;
    logic [psum_bw*col-1:0] ofifo_out;
    logic                   ofifo_rd;
    logic                   readout_start;
    logic [psum_bw*col-1:0] readout;
    logic                   readout_valid;
    logic                   tile_done;

    modport master (
        output kij, ofifo_valid, ofifo_out, readout_start,
        input  ofifo_rd, readout, readout_valid, tile_done
    );

    modport slave (
        input  kij, ofifo_valid, ofifo_out, readout_start,
        output ofifo_rd, readout, readout_valid, tile_done
    );
endinterface

// File: rtl/sfu_accum.sv
// Accumulates per-kij psum vectors into an output-pixel buffer and streams the result on request.
// Optional per-lane ReLU on readout is enabled by defining SFU_RELU_EN.
module sfu_accum #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned in_w    = 6,
    parameter int unsigned ksize   = 3
) (
    input logic        clk,
    input logic        reset,
    sfu_accum_if.slave io
);
    localparam int unsigned out_w    = in_w - ksize + 1;
    localparam int unsigned len_nij  = in_w * in_w;
    localparam int unsigned len_onij = out_w * out_w;
    localparam int unsigned n_kij    = ksize * ksize;
    localparam int unsigned vec_w    = psum_bw * col;
    localparam int unsigned nij_w    = $clog2(len_nij);
    localparam int unsigned onij_w   = $clog2(len_onij);
    localparam int unsigned rd_w     = $clog2(len_onij + 1);

    typedef enum logic {StAcc, StRead} state_e;

    state_e             state_q, state_d;
    logic [nij_w-1:0]   nij_cnt_q, nij_cnt_d;
    logic [3:0]         kij_q, kij_d;
    logic [rd_w-1:0]    rd_idx_q, rd_idx_d;
    logic [vec_w-1:0]   readout_q, readout_d;
    logic               readout_valid_q, readout_valid_d;
    logic               tile_done_q, tile_done_d;

    // Storage behaves like SRAM: deliberately not reset so partial sums survive per-kij resets.
    logic [vec_w-1:0]   psum_buf [len_onij];

    logic               pop;
    logic [3:0]         eff_kij;
    logic               hit;
    logic               wr_en;
    logic [onij_w-1:0]  wr_idx;
    logic [vec_w-1:0]   sum;
    logic [vec_w-1:0]   wr_data;
    int                 row, column, ki, kj, oy, ox;

    function automatic logic [vec_w-1:0] post_fn(input logic [vec_w-1:0] v);
        logic [vec_w-1:0] r;
        r = v;
`ifdef SFU_RELU_EN
        for (int l = 0; l < int'(col); l++) begin
            if (v[l*psum_bw + psum_bw - 1]) r[l*psum_bw +: psum_bw] = '0;
        end
`endif
        return r;
    endfunction

    // Address generation and lane-wise read-modify-write data for the current pop.
    always_comb begin
        pop     = (state_q == StAcc) && io.ofifo_valid && !reset;
        eff_kij = (nij_cnt_q == '0) ? io.kij : kij_q;
        row     = int'(nij_cnt_q) / int'(in_w);
        column  = int'(nij_cnt_q) % int'(in_w);
        ki      = int'(eff_kij) / int'(ksize);
        kj      = int'(eff_kij) % int'(ksize);
        oy      = row - ki;
        ox      = column - kj;
        hit     = (oy >= 0) && (oy < int'(out_w)) && (ox >= 0) && (ox < int'(out_w));
        wr_idx  = onij_w'(oy * int'(out_w) + ox);
        wr_en   = pop && hit && (int'(eff_kij) < int'(n_kij));
        sum     = '0;
        for (int l = 0; l < int'(col); l++) begin
            sum[l*psum_bw +: psum_bw] = psum_buf[wr_idx][l*psum_bw +: psum_bw]
                                      + io.ofifo_out[l*psum_bw +: psum_bw];
        end
        wr_data = (eff_kij == '0) ? io.ofifo_out : sum;
    end

    always_ff @(posedge clk) begin
        if (wr_en) psum_buf[wr_idx] <= wr_data;
    end

    always_comb begin
        state_d         = state_q;
        nij_cnt_d       = nij_cnt_q;
        kij_d           = kij_q;
        rd_idx_d        = rd_idx_q;
        readout_d       = readout_q;
        readout_valid_d = readout_valid_q;
        tile_done_d     = 1'b0;
        unique case (state_q)
            StAcc: begin
                if (pop) begin
                    if (nij_cnt_q == '0) kij_d = io.kij;
                    if (nij_cnt_q == nij_w'(len_nij - 1)) begin
                        nij_cnt_d   = '0;
                        tile_done_d = 1'b1;
                    end else begin
                        nij_cnt_d = nij_cnt_q + nij_w'(1);
                    end
                end
                if (io.readout_start && (nij_cnt_q == '0)) begin
                    state_d         = StRead;
                    rd_idx_d        = '0;
                    readout_d       = '0;
                    readout_valid_d = 1'b0;
                end
            end
            StRead: begin
                if (rd_idx_q == rd_w'(len_onij)) begin
                    state_d         = StAcc;
                    rd_idx_d        = '0;
                    readout_d       = '0;
                    readout_valid_d = 1'b0;
                end else begin
                    readout_d       = post_fn(psum_buf[rd_idx_q[onij_w-1:0]]);
                    readout_valid_d = 1'b1;
                    rd_idx_d        = rd_idx_q + rd_w'(1);
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StAcc;
            nij_cnt_q       <= '0;
            kij_q           <= '0;
            rd_idx_q        <= '0;
            readout_q       <= '0;
            readout_valid_q <= 1'b0;
            tile_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            nij_cnt_q       <= nij_cnt_d;
            kij_q           <= kij_d;
            rd_idx_q        <= rd_idx_d;
            readout_q       <= readout_d;
            readout_valid_q <= readout_valid_d;
            tile_done_q     <= tile_done_d;
        end
    end

    assign io.ofifo_rd      = pop;
    assign io.readout       = readout_q;
    assign io.readout_valid = readout_valid_q;
    assign io.tile_done     = tile_done_q;

endmodule

// File: tb/tb_sfu_accum.sv
// Directed bench for sfu_accum: accumulation mapping, wrap, ReLU, ignored start, readout timing.
module tb_sfu_accum;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sfu_accum_if #(.psum_bw(16), .col(8)) bus ();

    sfu_accum #(.psum_bw(16), .col(8), .in_w(6), .ksize(3)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int total = 0;
    int bad = 0;
    int td_cnt = 0;
    int td0;
    logic [127:0] rd_vals [16];
    logic [15:0]  neg_exp, wrap_exp;

    always @(posedge clk) if (bus.tile_done) td_cnt <= td_cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] lanes(input logic [15:0] v);
        return {8{v}};
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bus.ofifo_valid = 1'b0;
        bus.readout_start = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input int k, input int count, input int base, input bit use_n,
                        input bit exp_done);
        for (int n = 0; n < count; n++) begin
            @(negedge clk);
            bus.kij = 4'(k);
            bus.ofifo_valid = 1'b1;
            bus.ofifo_out = lanes(use_n ? 16'(base + n) : 16'(base));
            @(posedge clk);
        end
        @(negedge clk);
        bus.ofifo_valid = 1'b0;
        check("tile_done", 128'(bus.tile_done), 128'(exp_done));
    endtask

    // hold=1 keeps a vector offered throughout readout to prove the OFIFO is not popped.
    task automatic read_all(input bit hold);
        @(negedge clk);
        bus.readout_start = 1'b1;
        @(negedge clk);
        bus.readout_start = 1'b0;
        check("rd_latency", 128'(bus.readout_valid), 128'd0);
        if (hold) begin
            bus.kij = 4'd0;
            bus.ofifo_out = lanes(16'd0);
            bus.ofifo_valid = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("rd_valid", 128'(bus.readout_valid), 128'd1);
            rd_vals[i] = bus.readout;
            if (hold) check("rd_no_pop", 128'(bus.ofifo_rd), 128'd0);
        end
        @(negedge clk);
        check("rd_end_valid", 128'(bus.readout_valid), 128'd0);
        check("rd_end_data", bus.readout, 128'd0);
        if (hold) check("rd_resume_pop", 128'(bus.ofifo_rd), 128'd1);
    endtask

    initial begin
`ifdef SFU_RELU_EN
        neg_exp  = 16'h0000;
        wrap_exp = 16'h0000;
`else
        neg_exp  = 16'hFFFB;
        wrap_exp = 16'h8000;
`endif
        reset = 1'b1;
        bus.kij = 4'd0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out = '0;
        bus.readout_start = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_readout", bus.readout, 128'd0);
        check("rst_valid", 128'(bus.readout_valid), 128'd0);
        check("rst_rd", 128'(bus.ofifo_rd), 128'd0);
        check("rst_done", 128'(bus.tile_done), 128'd0);
        reset = 1'b0;

        // kij=0 overwrite with lanes = nij: onij o reads nij = oy*6+ox.
        push(0, 36, 0, 1'b1, 1'b1);
        read_all(1'b0);
        for (int o = 0; o < 16; o++) check("map_k0", rd_vals[o], lanes(16'((o / 4) * 6 + o % 4)));

        // Full 9-kij pass of ones: every onij collects 9.
        td0 = td_cnt;
        for (int k = 0; k < 9; k++) begin
            do_reset(2);
            push(k, 36, 1, 1'b0, 1'b1);
        end
        read_all(1'b0);
        check("td_count", 128'(td_cnt - td0), 128'd9);
        for (int o = 0; o < 16; o++) check("sum9", rd_vals[o], lanes(16'd9));

        // Negative values, then signed wrap 7FFF + 1.
        do_reset(2);
        push(0, 36, 'hFFFB, 1'b0, 1'b1);
        read_all(1'b0);
        for (int o = 0; o < 16; o++) check("neg", rd_vals[o], lanes(neg_exp));
        do_reset(2);
        push(0, 36, 'h7FFF, 1'b0, 1'b1);
        do_reset(2);
        push(1, 36, 1, 1'b0, 1'b1);
        read_all(1'b0);
        for (int o = 0; o < 16; o++) check("wrap", rd_vals[o], lanes(wrap_exp));

        // Partial kij=1 tile, ignored start, reset, then full kij=1 tile.
        do_reset(2);
        push(0, 36, 2, 1'b0, 1'b1);
        do_reset(2);
        push(1, 10, 1, 1'b0, 1'b0);
        @(negedge clk);
        bus.readout_start = 1'b1;
        @(negedge clk);
        bus.readout_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ign_start", 128'(bus.readout_valid), 128'd0);
        end
        do_reset(2);
        push(1, 36, 1, 1'b0, 1'b1);
        read_all(1'b0);
        // The 10-pop partial tile (nij 0..9) landed on onij 0..6 and is kept across reset.
        for (int o = 0; o < 16; o++) check("partial", rd_vals[o], lanes(o <= 6 ? 16'd4 : 16'd3));

        // OFIFO held valid across readout; nij 0 (value 0) pops on the first ACC cycle back.
        read_all(1'b1);
        check("hold_rd0", rd_vals[0], lanes(16'd4));
        check("hold_rd15", rd_vals[15], lanes(16'd3));
        push(0, 35, 1, 1'b1, 1'b1);
        read_all(1'b0);
        for (int o = 0; o < 16; o++) check("resume", rd_vals[o], lanes(16'((o / 4) * 6 + o % 4)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
